// File: rtl/bg_update_ctrl.sv
// Background-subtraction update controller: warm-up frame skipping, one-frame background
// load sequencing, and button-driven foreground threshold. Optional macro: BG_AUTO_LOAD_EN.
module bg_update_ctrl #(
    parameter int unsigned SKIP_FRAMES    = 2,
    parameter logic [8:0]  THRESH_DEFAULT = 9'd40,
    parameter logic [8:0]  THRESH_STEP    = 9'd4,
    parameter logic [8:0]  THRESH_MAX     = 9'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       capture_btn,
    input  logic       thr_up_btn,
    input  logic       thr_down_btn,
    output logic       load_frame,
    output logic       adapt_en,
    output logic [8:0] threshold,
    output logic [1:0] ctrl_state
);

    typedef enum logic [1:0] {
        WARM = 2'd0,
        ARM  = 2'd1,
        LOAD = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [3:0] SKIP_CNT = 4'(SKIP_FRAMES);

`ifdef BG_AUTO_LOAD_EN
    localparam state_t WARM_EXIT = ARM;
`else
    localparam state_t WARM_EXIT = RUN;
`endif

    function automatic logic [8:0] sat_up(input logic [8:0] thr);
        logic [9:0] sum;
        sum = {1'b0, thr} + {1'b0, THRESH_STEP};
        if (sum > {1'b0, THRESH_MAX}) begin
            return THRESH_MAX;
        end
        return sum[8:0];
    endfunction

    function automatic logic [8:0] sat_down(input logic [8:0] thr);
        logic signed [9:0] diff;
        diff = signed'({1'b0, thr}) - signed'({1'b0, THRESH_STEP});
        if (diff < 10'sd0) begin
            return 9'd0;
        end
        return diff[8:0];
    endfunction

    state_t     state_q, state_d;
    logic [3:0] frame_cnt_q, frame_cnt_d;
    logic       load_frame_q, load_frame_d;
    logic       adapt_en_q, adapt_en_d;
    logic [8:0] threshold_q, threshold_d;

    // Button history resets high so a button held through reset never looks like a press.
    logic       cap_prev_q, cap_prev_d;
    logic       up_prev_q, up_prev_d;
    logic       dn_prev_q, dn_prev_d;
    logic       cap_edge_q, cap_edge_d;
    logic       up_edge_q, up_edge_d;
    logic       dn_edge_q, dn_edge_d;

    always_comb begin
        cap_prev_d = capture_btn;
        up_prev_d  = thr_up_btn;
        dn_prev_d  = thr_down_btn;
        cap_edge_d = capture_btn & ~cap_prev_q;
        up_edge_d  = thr_up_btn & ~up_prev_q;
        dn_edge_d  = thr_down_btn & ~dn_prev_q;
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            WARM: begin
                if (frame_cnt_q == SKIP_CNT) begin
                    state_d = WARM_EXIT;
                end else if (frame_start) begin
                    frame_cnt_d = frame_cnt_q + 4'd1;
                end
            end
            ARM: begin
                if (frame_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (frame_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A capture wins over a coincident frame_start: re-arm, never jump straight to LOAD.
                if (cap_edge_q) begin
                    state_d = ARM;
                end
            end
            default: state_d = WARM;
        endcase
        load_frame_d = (state_d == LOAD);
        adapt_en_d   = (state_d == RUN);
    end

    always_comb begin
        threshold_d = threshold_q;
        if (up_edge_q && !dn_edge_q) begin
            threshold_d = sat_up(threshold_q);
        end else if (dn_edge_q && !up_edge_q) begin
            threshold_d = sat_down(threshold_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WARM;
            frame_cnt_q  <= 4'd0;
            load_frame_q <= 1'b0;
            adapt_en_q   <= 1'b0;
            threshold_q  <= THRESH_DEFAULT;
            cap_prev_q   <= 1'b1;
            up_prev_q    <= 1'b1;
            dn_prev_q    <= 1'b1;
            cap_edge_q   <= 1'b0;
            up_edge_q    <= 1'b0;
            dn_edge_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            load_frame_q <= load_frame_d;
            adapt_en_q   <= adapt_en_d;
            threshold_q  <= threshold_d;
            cap_prev_q   <= cap_prev_d;
            up_prev_q    <= up_prev_d;
            dn_prev_q    <= dn_prev_d;
            cap_edge_q   <= cap_edge_d;
            up_edge_q    <= up_edge_d;
            dn_edge_q    <= dn_edge_d;
        end
    end

    assign load_frame = load_frame_q;
    assign adapt_en   = adapt_en_q;
    assign threshold  = threshold_q;
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_bg_update_ctrl.sv
// Self-checking bench for bg_update_ctrl: threshold vector table with a scoreboard queue,
// plus hand-written warm-up, capture/load, and asynchronous-reset sequences.
module tb_bg_update_ctrl;

`ifdef BG_AUTO_LOAD_EN
    localparam int EXIT_ST = 1;
`else
    localparam int EXIT_ST = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       capture_btn;
    logic       thr_up_btn;
    logic       thr_down_btn;
    logic       load_frame, adapt_en;
    logic [8:0] threshold;
    logic [1:0] ctrl_state;
    logic       u0_load_frame, u0_adapt_en;
    logic [8:0] u0_threshold;
    logic [1:0] u0_ctrl_state;

    int n_cmp = 0;
    int n_bad = 0;
    int lf_cnt = 0;
    int u0_lf_cnt = 0;
    int ovl_cnt = 0;

    bg_update_ctrl #(.SKIP_FRAMES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .capture_btn(capture_btn),
        .thr_up_btn(thr_up_btn), .thr_down_btn(thr_down_btn), .load_frame(load_frame),
        .adapt_en(adapt_en), .threshold(threshold), .ctrl_state(ctrl_state)
    );

    bg_update_ctrl #(.SKIP_FRAMES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .capture_btn(capture_btn),
        .thr_up_btn(thr_up_btn), .thr_down_btn(thr_down_btn), .load_frame(u0_load_frame),
        .adapt_en(u0_adapt_en), .threshold(u0_threshold), .ctrl_state(u0_ctrl_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            lf_cnt    = lf_cnt + int'(load_frame);
            u0_lf_cnt = u0_lf_cnt + int'(u0_load_frame);
            if ((load_frame && adapt_en) || (u0_load_frame && u0_adapt_en)) ovl_cnt = ovl_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit up;
        bit dn;
        int reps;
        int exp_thr;
    } vec_t;

    vec_t tbl[10];
    int   exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic press_thr(input bit up, input bit dn);
        thr_up_btn   = up;
        thr_down_btn = dn;
        idle(2);
        thr_up_btn   = 1'b0;
        thr_down_btn = 1'b0;
        idle(2);
    endtask

    initial begin
        int mark;
        int prev_thr;
        int wrap_err;
        tbl[0] = '{1'b1, 1'b0, 1,  44};
        tbl[1] = '{1'b0, 1'b1, 1,  40};
        tbl[2] = '{1'b1, 1'b1, 1,  40};
        tbl[3] = '{1'b0, 1'b1, 1,  36};
        tbl[4] = '{1'b1, 1'b0, 1,  40};
        tbl[5] = '{1'b1, 1'b0, 60, 255};
        tbl[6] = '{1'b0, 1'b1, 70, 0};
        tbl[7] = '{1'b1, 1'b0, 25, 100};
        tbl[8] = '{1'b1, 1'b1, 1,  100};
        tbl[9] = '{1'b0, 1'b1, 15, 40};

        rst_n = 1'b1;
        frame_start = 1'b0;
        capture_btn = 1'b0;
        thr_up_btn = 1'b0;
        thr_down_btn = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", ctrl_state, 0);
        check("rst_load", load_frame, 0);
        check("rst_adapt", adapt_en, 0);
        check("rst_thr", threshold, 40);
        @(negedge clk) rst_n = 1'b1;
        cyc();
        check("skip0_state", u0_ctrl_state, EXIT_ST);
        check("skip0_adapt", u0_adapt_en, (EXIT_ST == 3) ? 1 : 0);
        check("skip0_load", u0_load_frame, 0);
        check("warm_state", ctrl_state, 0);

        wrap_err = 0;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(tbl[i].exp_thr);
            for (int r = 0; r < tbl[i].reps; r++) begin
                prev_thr = threshold;
                press_thr(tbl[i].up, tbl[i].dn);
                if (tbl[i].up && !tbl[i].dn && int'(threshold) < prev_thr) wrap_err++;
                if (tbl[i].dn && !tbl[i].up && int'(threshold) > prev_thr) wrap_err++;
            end
            check($sformatf("thr_vec%0d", i), threshold, exp_q.pop_front());
        end
        check("thr_no_wrap", wrap_err, 0);
        check("thr_in_warm", ctrl_state, 0);

        // Warm-up: two skipped frames
        pulse();
        check("warm_after_p1", ctrl_state, 0);
        idle(99);
        pulse();
        idle(99);
        check("warm_exit_state", ctrl_state, EXIT_ST);
        check("warm_exit_adapt", adapt_en, (EXIT_ST == 3) ? 1 : 0);
        check("warm_exit_load", load_frame, 0);
`ifdef BG_AUTO_LOAD_EN
        mark = lf_cnt;
        pulse();
        check("auto_load_state", ctrl_state, 2);
        check("auto_load_lf", load_frame, 1);
        idle(99);
        pulse();
        check("auto_load_len", lf_cnt - mark, 100);
        check("auto_run_state", ctrl_state, 3);
        check("auto_run_adapt", adapt_en, 1);
`else
        check("skip0_no_load", u0_lf_cnt, 0);
        check("noauto_no_load", lf_cnt, 0);
`endif

        // Capture in RUN, 10 cycles before a frame
        capture_btn = 1'b1;
        idle(10);
        check("cap_arm_state", ctrl_state, 1);
        check("cap_arm_adapt", adapt_en, 0);
        capture_btn = 1'b0;
        mark = lf_cnt;
        pulse();
        check("cap_load_state", ctrl_state, 2);
        check("cap_load_lf", load_frame, 1);
        idle(30);
        capture_btn = 1'b1;
        idle(10);
        capture_btn = 1'b0;
        idle(59);
        pulse();
        check("cap_load_len", lf_cnt - mark, 100);
        check("cap_run_state", ctrl_state, 3);
        check("cap_run_adapt", adapt_en, 1);
        check("cap_run_lf", load_frame, 0);
        idle(20);
        check("cap_in_load_ignored", ctrl_state, 3);

        // Capture edge coincident with frame_start
        capture_btn = 1'b1;
        cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        capture_btn = 1'b0;
        cyc();
        check("coinc_state", ctrl_state, 1);
        check("coinc_lf", load_frame, 0);
        pulse();
        check("coinc_load_state", ctrl_state, 2);

        // Asynchronous reset mid-LOAD with buttons held
        press_thr(1'b1, 1'b0);
        check("pre_rst_thr", threshold, 44);
        idle(44);
        check("pre_rst_state", ctrl_state, 2);
        rst_n = 1'b0;
        capture_btn = 1'b1;
        thr_up_btn = 1'b1;
        #1;
        check("async_rst_lf", load_frame, 0);
        check("async_rst_thr", threshold, 40);
        check("async_rst_state", ctrl_state, 0);
        check("async_rst_adapt", adapt_en, 0);
        @(negedge clk) rst_n = 1'b1;
        idle(6);
        check("held_thr", threshold, 40);
        check("held_state", ctrl_state, 0);
        check("held_u0_state", u0_ctrl_state, EXIT_ST);
        capture_btn = 1'b0;
        thr_up_btn = 1'b0;
        idle(3);
        check("no_overlap", ovl_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
